// File: rtl/conv_pkg.sv
// Shared FSM state type and width helpers for the streaming KxK convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, LOAD_COEF, STREAM, DRAIN} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Holds the sum of K*K full-width signed products without overflow.
  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 chained IMG_W-deep pixel delay rows; taps[i] is the pixel i+1 image rows above the input.
module conv_line_buffer #(
  parameter int DW    = 16,
  parameter int K     = 3,
  parameter int IMG_W = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic [DW-1:0]         pixel,
  output logic [K-2:0][DW-1:0]  taps
);

  logic [DW-1:0] rows [K-1][IMG_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K-1; i++)
        for (int j = 0; j < IMG_W; j++)
          rows[i][j] <= '0;
    end else if (shift_en) begin
      rows[0][0] <= pixel;
      for (int i = 1; i < K-1; i++)
        rows[i][0] <= rows[i-1][IMG_W-1];
      for (int i = 0; i < K-1; i++)
        for (int j = 1; j < IMG_W; j++)
          rows[i][j] <= rows[i][j-1];
    end
  end

  always_comb begin
    for (int i = 0; i < K-1; i++)
      taps[i] = rows[i][IMG_W-1];
  end

endmodule

// File: rtl/conv_stream_kxk.sv
// Streaming KxK signed fixed-point convolution over valid window positions; result registered on the edge
// accepting the completing pixel, pixels stall while a result waits. Define SATURATE_EN to clamp instead of wrap.
module conv_stream_kxk
  import conv_pkg::*;
#(
  parameter int DW    = 16,
  parameter int K     = 3,
  parameter int IMG_W = 7,
  parameter int IMG_H = 7,
  parameter int FRAC  = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          keep_coef,
  input  logic          coef_valid,
  input  logic [DW-1:0] coef_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  localparam int ACC_W = acc_width(DW, K);
  localparam int NC    = K * K;
  localparam int IW    = clog2(NC);
  localparam int CW    = clog2(IMG_W);
  localparam int RW    = clog2(IMG_H);
  localparam logic [IW-1:0] COEF_LAST = IW'(NC - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);

  state_t state, state_nxt;
  logic   done_nxt;
  logic   accept, last_pix, win_ok;

  logic [IW-1:0]        coef_idx;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic signed [DW-1:0] coef [NC];
  // Only the K-1 surviving columns are stored; the new right column comes straight from the taps.
  logic signed [DW-1:0] win [K][K-1];
  logic signed [DW-1:0] win_nxt [K][K];
  logic [K-2:0][DW-1:0] taps;

  logic signed [ACC_W-1:0] acc, acc_sh;
  logic [DW-1:0]           res;

  assign accept   = in_valid && in_ready;
  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
  assign win_ok   = (row >= RW'(K - 1)) && (col >= CW'(K - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE:      if (start) state_nxt = keep_coef ? STREAM : LOAD_COEF;
      LOAD_COEF: if (coef_valid && coef_idx == COEF_LAST) state_nxt = STREAM;
      STREAM: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && (!out_valid || out_ready) && last_pix) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!out_valid || out_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  conv_line_buffer #(.DW(DW), .K(K), .IMG_W(IMG_W)) u_line_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .pixel    (in_data),
    .taps     (taps)
  );

  always_comb begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K-1; c++)
        win_nxt[r][c] = win[r][c];
    for (int r = 0; r < K-1; r++)
      win_nxt[r][K-1] = taps[K-2-r];
    win_nxt[K-1][K-1] = in_data;
  end

  always_comb begin
    acc = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        acc = acc + ACC_W'((2*DW)'(coef[r*K+c]) * (2*DW)'(win_nxt[r][c]));
  end

  assign acc_sh = acc >>> FRAC;

`ifdef SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  always_comb begin
    if (acc_sh > SAT_HI)      res = SAT_HI[DW-1:0];
    else if (acc_sh < SAT_LO) res = SAT_LO[DW-1:0];
    else                      res = acc_sh[DW-1:0];
  end
`else
  logic unused_hi;
  assign res       = acc_sh[DW-1:0];
  assign unused_hi = ^acc_sh[ACC_W-1:DW];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_idx  <= '0;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < NC; i++) coef[i] <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K-1; c++)
          win[r][c] <= '0;
    end else begin
      if (state == IDLE && start) begin
        coef_idx <= '0;
        col      <= '0;
        row      <= '0;
      end
      if (state == LOAD_COEF && coef_valid) begin
        coef[coef_idx] <= coef_data;
        coef_idx       <= (coef_idx == COEF_LAST) ? '0 : coef_idx + 1'b1;
      end
      if (accept) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K-1; c++)
            win[r][c] <= win_nxt[r][c+1];
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (accept && win_ok) begin
        out_valid <= 1'b1;
        out_data  <= res;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/conv_stream_kxk.md
Name: conv_stream_kxk

Overview:
Parametrised streaming KxK signed fixed-point 2-D convolution engine, the successor to the fixed 3x3/7x7 engine.
- Loads K*K kernel coefficients, then accepts a raster-order IMG_W x IMG_H pixel stream through valid/ready handshakes.
- Emits one result per valid ("same-free", no padding) window position with output backpressure.
- Sits between the pixel DMA/feeder and the result writer in the accelerator datapath.

Parameters:
DW, 16, signed width of coefficients, pixels and results
K, 3, kernel side length (K >= 2)
IMG_W, 7, image width in pixels (IMG_W >= K)
IMG_H, 7, image height in pixels (IMG_H >= K)
FRAC, 12, fractional bits of coefficient format; product sum is arithmetically shifted right by FRAC

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle frame start request; honoured only in IDLE
keep_coef  in  1  sampled with start; 1 = skip coefficient load, reuse stored kernel
coef_valid  in  1  coefficient beat valid (always accepted in LOAD_COEF)
coef_data  in  DW  coefficient, row-major order, index 0 = top-left
in_valid  in  1  pixel beat valid
in_ready  out  1  pixel accepted when in_valid && in_ready
in_data  in  DW  pixel, raster order
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_data  out  DW  convolution result
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last result handshake

Behaviour:
- Reset: state IDLE; out_valid=0, out_data=0, in_ready=0, busy=0, done=0; coefficients, window, line buffers and counters cleared to 0.
- Reset mid-frame aborts immediately; no partial output survives.
- States:
  - IDLE: start && !keep_coef -> LOAD_COEF; start && keep_coef -> STREAM.
  - LOAD_COEF: each coef_valid cycle writes coef[idx], idx++. After beat K*K-1 -> STREAM.
  - STREAM: in_ready = !out_valid || out_ready. On each accepted pixel:
    - Shift the KxK window left.
    - Load a new right column of K-1 line-buffer taps plus in_data (in_data = bottom row).
    - Push in_data into the line buffers.
    - Advance col/row counters; col wraps to 0 at IMG_W-1 and row increments.
  - DRAIN: entered after pixel (IMG_H-1, IMG_W-1) is accepted. in_ready=0. Leave when no result is pending (out_valid=0, or handshake this cycle) -> IDLE with done=1 for one cycle.
- Window validity: a result is produced for an accepted pixel iff row >= K-1 and col >= K-1. Window columns never straddle a row boundary.
- Results per frame: (IMG_W-K+1)*(IMG_H-K+1), which is 25 for the defaults.
- Latency: result registered on the same clk edge that accepts the completing pixel. The dot product is computed combinationally on the next-window value. out_valid is high from the following cycle.
- out_valid/out_data hold until out_ready. A new result may load on the same edge as the handshake (full throughput, 1 pixel/cycle).
- Arithmetic: products are full signed 2*DW. Sum is held in ACC_W = 2*DW + clog2(K*K) bits, no intermediate overflow. Result = (sum >>> FRAC) truncated to the low DW bits (wrap).
- Coefficient beats outside LOAD_COEF are ignored. start while busy is ignored.
- in_valid while in_ready=0 is not consumed.

Optional Feature:
SATURATE_EN
- Defined: (sum >>> FRAC) clamps to [-2^(DW-1), 2^(DW-1)-1], i.e. 0x8000..0x7FFF for DW=16.
- Undefined: plain truncation (wrap) as above.

Decomposition:
- Package conv_pkg: state enum (IDLE, LOAD_COEF, STREAM, DRAIN), ACC_W derivation function, clog2 helper.
- One sub-module, conv_line_buffer: K-1 chained IMG_W-deep shift rows of DW bits, with shift enable and K-1 tap outputs.

Test Plan:
1. Identity kernel (centre coef=0x1000, rest 0), pixel(r,c)=r*7+c, out_ready=1 -> 25 results equal to centre pixels 8,9,10,11,12,15,…,40; done pulses once; busy falls the same cycle.
2. All-ones kernel (0x1000 x9), all pixels 0x1000 -> every result 0x9000 (wrap) without SATURATE_EN; 0x7FFF with it.
3. Random kernel/pixels with out_ready toggling randomly and in_valid gaps -> result stream bit-matches the reference model in order; in_ready=0 whenever out_valid && !out_ready; no result lost or duplicated.
4. Second frame with start+keep_coef=1 and no coef beats -> STREAM entered directly; results use the prior kernel; stray coef_valid pulses ignored.
5. rst_n asserted after 20 pixels -> all outputs zero immediately. Restart with a full load -> correct 25 results, no stale window data.
6. start pulsed during STREAM, and K=5, IMG_W=8, IMG_H=6 build -> start ignored; 4*2=8 results produced.
